// File: rtl/shell_cmd_responder.sv
// shell_cmd_responder: drains one typed command line, matches it against a fixed command set and
// streams one reply line back, then closes with in_solved/out_solved. SHELL_CNT_CMD_EN adds the "cnt" command.
module shell_cmd_responder #(
  parameter int CMD_MAX  = 32,
  parameter int ECHO_MAX = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       out_newASCII_ready,
  input  logic [5:0] out_lineLen,
  input  logic [7:0] lineOut,
  output logic       lineOut_nextASCII,
  output logic       in_newASCII_ready,
  output logic [7:0] lineIn,
  input  logic       lineIn_nextASCII,
  output logic       in_solved,
  input  logic       out_solved
);
  localparam int             AW         = $clog2(CMD_MAX);
  localparam logic [5:0]     CMD_MAX_C  = 6'(CMD_MAX);
  localparam logic [6:0]     CMD_MAX_W7 = 7'(CMD_MAX);
  localparam logic [6:0]     ECHO_MAX_C = 7'(ECHO_MAX);
  localparam logic [151:0]   HELP_STR   = "cmds: echo help ver";
  localparam logic [95:0]    VER_STR    = "SSshell v1.0";
  localparam logic [135:0]   NF_STR     = "command not found";

  typedef enum logic [2:0] {S_IDLE, S_RX, S_RX_GAP, S_PARSE, S_TX, S_SOLVE} state_t;
  typedef enum logic [2:0] {R_NONE, R_HELP, R_VER, R_ECHO, R_NOTFOUND, R_CNT} reply_t;

  state_t       state_q, state_d;
  reply_t       kind_q, kind_d, parse_kind, sel_kind;
  logic [5:0]   rx_cnt_q, rx_cnt_d;
  logic [6:0]   tx_idx_q, tx_idx_d, len_q, len_d;
  logic [6:0]   parse_len, sel_len, sel_idx, echo_len, echo_addr;
  logic         next_q, next_d, rdy_q, rdy_d, solved_q, solved_d;
  logic [7:0]   line_in_q, line_in_d, sel_byte;
  logic         buf_we;
  logic [7:0]   buf_mem [CMD_MAX];
  logic [151:0] help_sh;
  logic [95:0]  ver_sh;
  logic [135:0] nf_sh;
`ifdef SHELL_CNT_CMD_EN
  logic [7:0]   cmd_cnt_q, cmd_cnt_d;
`endif

  assign lineOut_nextASCII = next_q;
  assign in_newASCII_ready = rdy_q;
  assign lineIn            = line_in_q;
  assign in_solved         = solved_q;

  // Command match on the captured line; only meaningful while in PARSE.
  always_comb begin
    echo_len = {1'b0, rx_cnt_q} - 7'd5;
    if (echo_len > ECHO_MAX_C) echo_len = ECHO_MAX_C;
    parse_kind = R_NOTFOUND;
    parse_len  = 7'd17;
    if (rx_cnt_q == 6'd0) begin
      parse_kind = R_NONE;
      parse_len  = 7'd0;
    end else if (rx_cnt_q == 6'd4 && buf_mem[0] == "h" && buf_mem[1] == "e" &&
                 buf_mem[2] == "l" && buf_mem[3] == "p") begin
      parse_kind = R_HELP;
      parse_len  = 7'd19;
    end else if (rx_cnt_q == 6'd3 && buf_mem[0] == "v" && buf_mem[1] == "e" &&
                 buf_mem[2] == "r") begin
      parse_kind = R_VER;
      parse_len  = 7'd12;
    end else if (rx_cnt_q >= 6'd4 && buf_mem[0] == "e" && buf_mem[1] == "c" &&
                 buf_mem[2] == "h" && buf_mem[3] == "o") begin
      if (rx_cnt_q == 6'd4) begin
        parse_kind = R_NONE;
        parse_len  = 7'd0;
      end else if (buf_mem[4] == " ") begin
        parse_kind = (echo_len == 7'd0) ? R_NONE : R_ECHO;
        parse_len  = echo_len;
      end
    end
`ifdef SHELL_CNT_CMD_EN
    else if (rx_cnt_q == 6'd3 && buf_mem[0] == "c" && buf_mem[1] == "n" &&
             buf_mem[2] == "t") begin
      parse_kind = R_CNT;
      parse_len  = 7'd3;
    end
`endif
  end

  // Byte that lineIn must present next: reply[0] when leaving PARSE, reply[tx_idx+1] on advance.
  always_comb begin
    if (state_q == S_PARSE) begin
      sel_kind = parse_kind;
      sel_len  = parse_len;
      sel_idx  = 7'd0;
    end else begin
      sel_kind = kind_q;
      sel_len  = len_q;
      sel_idx  = tx_idx_q + 7'd1;
    end
    help_sh   = HELP_STR << {sel_idx, 3'b000};
    ver_sh    = VER_STR << {sel_idx, 3'b000};
    nf_sh     = NF_STR << {sel_idx, 3'b000};
    echo_addr = sel_idx + 7'd5;
    sel_byte  = 8'd0;
    if (sel_idx < sel_len) begin
      case (sel_kind)
        R_HELP:     sel_byte = help_sh[151:144];
        R_VER:      sel_byte = ver_sh[95:88];
        R_NOTFOUND: sel_byte = nf_sh[135:128];
        R_ECHO: begin
          if (echo_addr < CMD_MAX_W7) sel_byte = buf_mem[echo_addr[AW-1:0]];
        end
`ifdef SHELL_CNT_CMD_EN
        R_CNT: begin
          case (sel_idx[1:0])
            2'd0:    sel_byte = 8'h30 + (cmd_cnt_q / 8'd100);
            2'd1:    sel_byte = 8'h30 + ((cmd_cnt_q / 8'd10) % 8'd10);
            default: sel_byte = 8'h30 + (cmd_cnt_q % 8'd10);
          endcase
        end
`endif
        default: sel_byte = 8'd0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    rx_cnt_d  = rx_cnt_q;
    tx_idx_d  = tx_idx_q;
    len_d     = len_q;
    next_d    = 1'b0;
    rdy_d     = rdy_q;
    solved_d  = solved_q;
    line_in_d = line_in_q;
    buf_we    = 1'b0;
`ifdef SHELL_CNT_CMD_EN
    cmd_cnt_d = cmd_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (out_newASCII_ready) begin
          state_d  = S_RX;
          rx_cnt_d = 6'd0;
        end
      end
      S_RX: begin
        if (lineOut == 8'd0 || rx_cnt_q == out_lineLen || !out_newASCII_ready) begin
          state_d = S_PARSE;
`ifdef SHELL_CNT_CMD_EN
          cmd_cnt_d = cmd_cnt_q + 8'd1;
`endif
        end else begin
          // Bytes past the buffer are still acknowledged so the terminal drains its line.
          if (rx_cnt_q < CMD_MAX_C) begin
            buf_we   = 1'b1;
            rx_cnt_d = rx_cnt_q + 6'd1;
          end
          next_d  = 1'b1;
          state_d = S_RX_GAP;
        end
      end
      S_RX_GAP: state_d = S_RX;
      S_PARSE: begin
        kind_d   = parse_kind;
        len_d    = parse_len;
        tx_idx_d = 7'd0;
        if (parse_len == 7'd0) begin
          state_d  = S_SOLVE;
          solved_d = 1'b1;
        end else begin
          state_d   = S_TX;
          rdy_d     = 1'b1;
          line_in_d = sel_byte;
        end
      end
      S_TX: begin
        if (lineIn_nextASCII) begin
          if (line_in_q != 8'd0) begin
            tx_idx_d  = tx_idx_q + 7'd1;
            line_in_d = sel_byte;
          end else begin
            rdy_d     = 1'b0;
            line_in_d = 8'd0;
            solved_d  = 1'b1;
            state_d   = S_SOLVE;
          end
        end
      end
      S_SOLVE: begin
        if (out_solved) begin
          solved_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      kind_q    <= R_NONE;
      rx_cnt_q  <= 6'd0;
      tx_idx_q  <= 7'd0;
      len_q     <= 7'd0;
      next_q    <= 1'b0;
      rdy_q     <= 1'b0;
      solved_q  <= 1'b0;
      line_in_q <= 8'd0;
`ifdef SHELL_CNT_CMD_EN
      cmd_cnt_q <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_idx_q  <= tx_idx_d;
      len_q     <= len_d;
      next_q    <= next_d;
      rdy_q     <= rdy_d;
      solved_q  <= solved_d;
      line_in_q <= line_in_d;
`ifdef SHELL_CNT_CMD_EN
      cmd_cnt_q <= cmd_cnt_d;
`endif
    end
  end

  // Line buffer carries no reset; only bytes below rx_cnt are ever read.
  always_ff @(posedge clk) begin
    if (buf_we) buf_mem[rx_cnt_q[AW-1:0]] <= lineOut;
  end

endmodule

// File: tb/tb_shell_cmd_responder.sv
// Bench for shell_cmd_responder: emulates the terminal (line source, reply sink, solve handshake)
// and checks every reply byte against a string-level model of the command set.
module tb_shell_cmd_responder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       out_newASCII_ready = 1'b0;
  logic [5:0] out_lineLen;
  logic [7:0] lineOut;
  logic       lineOut_nextASCII;
  logic       in_newASCII_ready;
  logic [7:0] lineIn;
  logic       lineIn_nextASCII = 1'b0;
  logic       in_solved;
  logic       out_solved = 1'b0;

  logic [7:0] cmd_bytes [64];
  int         cmd_len   = 0;
  int         src_idx   = 0;
  int         pulse_cnt = 0;
  int         tx_pos    = 0;
  string      exp_str   = "";
  int         model_cnt = 0;
  int         n_checks  = 0;
  int         n_fail    = 0;

  shell_cmd_responder dut (
    .clk               (clk),
    .rst               (rst),
    .out_newASCII_ready(out_newASCII_ready),
    .out_lineLen       (out_lineLen),
    .lineOut           (lineOut),
    .lineOut_nextASCII (lineOut_nextASCII),
    .in_newASCII_ready (in_newASCII_ready),
    .lineIn            (lineIn),
    .lineIn_nextASCII  (lineIn_nextASCII),
    .in_solved         (in_solved),
    .out_solved        (out_solved)
  );

  always #5 clk = ~clk;

  assign out_lineLen = 6'(cmd_len);
  assign lineOut     = (src_idx < cmd_len) ? cmd_bytes[src_idx] : 8'd0;

  // Terminal-side indices: source advances on each take pulse, sink position on each consume.
  always @(posedge clk) begin
    if (lineOut_nextASCII) pulse_cnt <= pulse_cnt + 1;
    if (!out_newASCII_ready) src_idx <= 0;
    else if (lineOut_nextASCII) src_idx <= src_idx + 1;
    if (rst || in_solved) tx_pos <= 0;
    else if (lineIn_nextASCII && in_newASCII_ready) tx_pos <= tx_pos + 1;
  end

  function automatic string model_reply(input string cmd, input int cnt);
    string p;
    if (cmd == "help") return "cmds: echo help ver";
    if (cmd == "ver") return "SSshell v1.0";
    if (cmd == "" || cmd == "echo") return "";
    if (cmd.len() >= 5 && cmd.substr(0, 4) == "echo ") begin
      p = cmd.substr(5, cmd.len() - 1);
      if (p.len() > 27) p = p.substr(0, 26);
      return p;
    end
`ifdef SHELL_CNT_CMD_EN
    if (cmd == "cnt") return $sformatf("%03d", cnt);
`endif
    return "command not found";
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, act, exp);
    end
  endtask

  // One full command transaction; abort_after>=0 stops after that many reply bytes (for reset tests).
  task automatic run_cmd(input string cmd, input int max_stall, input int abort_after,
                         output string got);
    int  cyc, p0, st, guard;
    byte b;
    bit  saw_zero;
    model_cnt = (model_cnt + 1) % 256;
    exp_str   = model_reply(cmd, model_cnt);
    cmd_len   = cmd.len();
    for (int i = 0; i < cmd_len; i++) cmd_bytes[i] = cmd[i];
    got      = "";
    saw_zero = 1'b0;
    @(negedge clk);
    p0 = pulse_cnt;
    out_newASCII_ready = 1'b1;
    cyc = 0;
    while (!in_newASCII_ready && !in_solved && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    out_newASCII_ready = 1'b0;
    if (cyc >= 300) chk({cmd, "_start_timeout"}, cyc, 0);
    if (cmd_len == 0) chk("empty_solve_within_3", int'(cyc <= 3), 1);
    guard = 0;
    while (in_newASCII_ready && guard < 100) begin
      if (abort_after >= 0 && guard == abort_after) return;
      b = lineIn;
      if (b != 0) got = $sformatf("%s%c", got, b);
      else saw_zero = 1'b1;
      st = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
      repeat (st) @(negedge clk);
      lineIn_nextASCII = 1'b1;
      @(negedge clk);
      lineIn_nextASCII = 1'b0;
      @(negedge clk);
      guard++;
      if (b == 0) break;
    end
    chk_s({cmd, "_reply"}, got, exp_str);
    chk({cmd, "_nextASCII_pulses"}, pulse_cnt - p0, cmd_len);
    if (exp_str.len() > 0) chk({cmd, "_terminator_seen"}, int'(saw_zero), 1);
    chk({cmd, "_ready_low_after"}, int'(in_newASCII_ready), 0);
    chk({cmd, "_solved_set"}, int'(in_solved), 1);
    repeat (3) @(negedge clk);
    chk({cmd, "_solved_held"}, int'(in_solved), 1);
    out_solved = 1'b1;
    @(negedge clk);
    out_solved = 1'b0;
    chk({cmd, "_solved_cleared"}, int'(in_solved), 0);
    @(negedge clk);
  endtask

  initial begin
    string got, long_cmd, a27;
    fork
      forever begin
        @(negedge clk);
        if (!rst) begin
          chk("mon_exclusive", int'(lineOut_nextASCII && in_newASCII_ready), 0);
          if (in_newASCII_ready)
            chk("mon_lineIn", int'(lineIn),
                (tx_pos < exp_str.len()) ? int'(exp_str[tx_pos]) : 0);
          else
            chk("mon_lineIn_idle", int'(lineIn), 0);
          if (exp_str.len() == 0) chk("mon_no_reply", int'(in_newASCII_ready), 0);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_nextASCII", int'(lineOut_nextASCII), 0);
    chk("rst_ready", int'(in_newASCII_ready), 0);
    chk("rst_lineIn", int'(lineIn), 0);
    chk("rst_solved", int'(in_solved), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_cmd("help", 0, -1, got);
    $display("cmd \"help\" -> \"%s\"", got);
    chk_s("lit_help", got, "cmds: echo help ver");
    run_cmd("echo hi", 0, -1, got);
    $display("cmd \"echo hi\" -> \"%s\"", got);
    chk_s("lit_echo_hi", got, "hi");
    run_cmd("", 0, -1, got);
    $display("cmd \"\" -> \"%s\"", got);
    chk_s("lit_empty", got, "");
    run_cmd("foo", 0, -1, got);
    $display("cmd \"foo\" -> \"%s\"", got);
    chk_s("lit_foo", got, "command not found");
    run_cmd("foo", 20, -1, got);
    $display("cmd \"foo\" stalled -> \"%s\"", got);
    chk_s("lit_foo_stall", got, "command not found");

    long_cmd = "echo ";
    a27 = "";
    for (int i = 0; i < 27; i++) begin
      long_cmd = {long_cmd, "a"};
      a27 = {a27, "a"};
    end
    run_cmd(long_cmd, 0, -1, got);
    $display("cmd \"echo +27a\" -> %0d bytes", got.len());
    chk_s("lit_echo_27a", got, a27);
    run_cmd("echo", 0, -1, got);
    $display("cmd \"echo\" -> \"%s\"", got);
    chk_s("lit_echo_bare", got, "");
    run_cmd("echo ", 0, -1, got);
    $display("cmd \"echo \" -> \"%s\"", got);
    run_cmd("Help", 0, -1, got);
    $display("cmd \"Help\" -> \"%s\"", got);
    chk_s("lit_case_sensitive", got, "command not found");
    run_cmd("helpx", 0, -1, got);
    $display("cmd \"helpx\" -> \"%s\"", got);
`ifndef SHELL_CNT_CMD_EN
    run_cmd("cnt", 0, -1, got);
    $display("cmd \"cnt\" -> \"%s\"", got);
    chk_s("lit_cnt_disabled", got, "command not found");
`endif

    // Reset in the middle of a reply must clear every output without waiting for a clock edge.
    run_cmd("help", 0, 3, got);
    rst = 1'b1;
    #1;
    chk("async_rst_nextASCII", int'(lineOut_nextASCII), 0);
    chk("async_rst_ready", int'(in_newASCII_ready), 0);
    chk("async_rst_lineIn", int'(lineIn), 0);
    chk("async_rst_solved", int'(in_solved), 0);
    $display("reset asserted mid-reply");
    model_cnt = 0;
    exp_str = "";
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd("ver", 0, -1, got);
    $display("cmd \"ver\" -> \"%s\"", got);
    chk_s("lit_ver_after_rst", got, "SSshell v1.0");
`ifdef SHELL_CNT_CMD_EN
    rst = 1'b1;
    model_cnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd("cnt", 0, -1, got);
    $display("cmd \"cnt\" -> \"%s\"", got);
    chk_s("lit_cnt_1", got, "001");
    run_cmd("cnt", 0, -1, got);
    $display("cmd \"cnt\" -> \"%s\"", got);
    chk_s("lit_cnt_2", got, "002");
    run_cmd("cnt", 5, -1, got);
    $display("cmd \"cnt\" -> \"%s\"", got);
    chk_s("lit_cnt_3", got, "003");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
